// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_unit
// Description : Multi-lane writeback/commit stage with load formatting,
//               RVFI retire order and a saturating retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_unit #(
    parameter int N_LANES   = 2,
    parameter int COUNTER_W = 32,
    parameter int ORDER_W   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         dside_stall_n_i,
    input  logic                         istall_n_i,
    input  logic                         flush_i,
    input  logic [N_LANES-1:0]           in_valid_i,
    input  logic [N_LANES-1:0]           in_reg_write_i,
    input  logic [N_LANES-1:0]           in_is_load_i,
    input  logic [N_LANES*5-1:0]         in_rd_addr_i,
    input  logic [N_LANES*3-1:0]         in_funct3_i,
    input  logic [N_LANES*2-1:0]         in_addr_lo_i,
    input  logic [N_LANES*32-1:0]        in_alu_result_i,
    input  logic [N_LANES*32-1:0]        in_load_line_i,
    output logic [N_LANES-1:0]           rf_we_o,
    output logic [N_LANES*5-1:0]         rf_waddr_o,
    output logic [N_LANES*32-1:0]        rf_wdata_o,
    output logic [N_LANES-1:0]           ret_valid_o,
    output logic [N_LANES*ORDER_W-1:0]   ret_order_o,
    output logic [COUNTER_W-1:0]         retire_count_o
);

    localparam int CNT_W = $clog2(N_LANES + 1);

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] line);
        logic [15:0] sh;
        sh = 16'(line >> {lo, 3'b000});
        case (f3)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b100:  fmt_load = {24'b0, sh[7:0]};
            3'b101:  fmt_load = {16'b0, sh[15:0]};
            default: fmt_load = line;
        endcase
    endfunction

    logic                       w_take;
    logic [N_LANES-1:0]         w_acc;
    logic [N_LANES-1:0]         w_we_raw;
    logic [N_LANES-1:0]         w_we;
    logic [N_LANES*32-1:0]      w_wdata;
    logic [N_LANES*ORDER_W-1:0] w_order;
    logic [CNT_W-1:0]           w_prefix [N_LANES+1];
    logic [COUNTER_W:0]         w_cnt_sum;

    logic [N_LANES-1:0]         we_q;
    logic [N_LANES-1:0]         valid_q;
    logic [N_LANES*5-1:0]       waddr_q;
    logic [N_LANES*32-1:0]      wdata_q;
    logic [N_LANES*ORDER_W-1:0] order_q;
    logic [ORDER_W-1:0]         base_q, base_d;
    logic [COUNTER_W-1:0]       cnt_q, cnt_d;

    // Flush only matters when the pipe advances; a stalled cycle is already a bubble.
    assign w_take = dside_stall_n_i & istall_n_i & ~flush_i;
    assign w_acc  = in_valid_i & {N_LANES{w_take}};

    always_comb begin
        w_prefix[0] = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_prefix[k+1] = w_prefix[k] + CNT_W'(w_acc[k]);
        end
    end

    generate
        for (genvar k = 0; k < N_LANES; k++) begin : g_lane
            logic [4:0]  w_rd;
            logic [31:0] w_res;
            assign w_rd        = in_rd_addr_i[k*5 +: 5];
            assign w_we_raw[k] = w_acc[k] & in_reg_write_i[k] & (w_rd != 5'd0);
            assign w_res       = in_is_load_i[k]
                               ? fmt_load(in_funct3_i[k*3 +: 3], in_addr_lo_i[k*2 +: 2],
                                          in_load_line_i[k*32 +: 32])
                               : in_alu_result_i[k*32 +: 32];
            assign w_wdata[k*32 +: 32]          = (w_rd == 5'd0) ? 32'd0 : w_res;
            assign w_order[k*ORDER_W +: ORDER_W] = base_q + ORDER_W'(w_prefix[k]);
        end
    endgenerate

    // Older lane loses its write when a younger lane targets the same rd.
    always_comb begin
        w_we = w_we_raw;
        for (int j = 0; j < N_LANES; j++) begin
            for (int k = j + 1; k < N_LANES; k++) begin
                if (w_we_raw[k] && (in_rd_addr_i[k*5 +: 5] == in_rd_addr_i[j*5 +: 5])) begin
                    w_we[j] = 1'b0;
                end
            end
        end
    end

    assign w_cnt_sum = {1'b0, cnt_q} + (COUNTER_W+1)'(w_prefix[N_LANES]);
    assign cnt_d     = w_cnt_sum[COUNTER_W] ? {COUNTER_W{1'b1}} : w_cnt_sum[COUNTER_W-1:0];
    assign base_d    = base_q + ORDER_W'(w_prefix[N_LANES]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= '0;
            valid_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            order_q <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= '0;
            valid_q <= '0;
            if (w_take) begin
                we_q    <= w_we;
                valid_q <= w_acc;
                waddr_q <= in_rd_addr_i;
                wdata_q <= w_wdata;
                order_q <= w_order;
                base_q  <= base_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign rf_we_o        = we_q;
    assign rf_waddr_o     = waddr_q;
    assign rf_wdata_o     = wdata_q;
    assign ret_valid_o    = valid_q;
    assign ret_order_o    = order_q;
    assign retire_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_commit_unit
// Description : Directed self-checking bench for wb_commit_unit (2 lanes,
//               4-bit counter so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_unit;

    localparam int N  = 2;
    localparam int CW = 4;
    localparam int OW = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            dside_stall_n_i, istall_n_i, flush_i;
    logic [N-1:0]    in_valid_i, in_reg_write_i, in_is_load_i;
    logic [N*5-1:0]  in_rd_addr_i;
    logic [N*3-1:0]  in_funct3_i;
    logic [N*2-1:0]  in_addr_lo_i;
    logic [N*32-1:0] in_alu_result_i, in_load_line_i;
    logic [N-1:0]    rf_we_o, ret_valid_o;
    logic [N*5-1:0]  rf_waddr_o;
    logic [N*32-1:0] rf_wdata_o;
    logic [N*OW-1:0] ret_order_o;
    logic [CW-1:0]   retire_count_o;

    int total = 0;
    int bad   = 0;

    wb_commit_unit #(.N_LANES(N), .COUNTER_W(CW), .ORDER_W(OW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dside_stall_n_i(dside_stall_n_i), .istall_n_i(istall_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_reg_write_i(in_reg_write_i), .in_is_load_i(in_is_load_i),
        .in_rd_addr_i(in_rd_addr_i), .in_funct3_i(in_funct3_i), .in_addr_lo_i(in_addr_lo_i),
        .in_alu_result_i(in_alu_result_i), .in_load_line_i(in_load_line_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .ret_valid_o(ret_valid_o), .ret_order_o(ret_order_o), .retire_count_o(retire_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic lane(input int k, input logic v, input logic rw, input logic ld,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] line);
        in_valid_i[k]              = v;
        in_reg_write_i[k]          = rw;
        in_is_load_i[k]            = ld;
        in_rd_addr_i[k*5 +: 5]     = rd;
        in_funct3_i[k*3 +: 3]      = f3;
        in_addr_lo_i[k*2 +: 2]     = lo;
        in_alu_result_i[k*32 +: 32] = alu;
        in_load_line_i[k*32 +: 32]  = line;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_ret(input string tag, input logic [1:0] vld, input logic [1:0] we,
                           input logic [63:0] o0, input logic [63:0] o1, input logic [3:0] cnt);
        chk({tag, ".valid"}, 64'(ret_valid_o), 64'(vld));
        chk({tag, ".we"},    64'(rf_we_o),     64'(we));
        chk({tag, ".ord0"},  ret_order_o[0 +: OW],  o0);
        chk({tag, ".ord1"},  ret_order_o[OW +: OW], o1);
        chk({tag, ".cnt"},   64'(retire_count_o), 64'(cnt));
    endtask

    initial begin
        rst_ni = 1'b0; dside_stall_n_i = 1'b1; istall_n_i = 1'b1; flush_i = 1'b0;
        in_valid_i = '0; in_reg_write_i = '0; in_is_load_i = '0; in_rd_addr_i = '0;
        in_funct3_i = '0; in_addr_lo_i = '0; in_alu_result_i = '0; in_load_line_i = '0;
        repeat (2) step();
        chk_ret("reset", 2'b00, 2'b00, 64'd0, 64'd0, 4'd0);
        chk("reset.wdata", 64'(rf_wdata_o), 64'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Two ALU results
        lane(0, 1, 1, 0, 5'd5, 3'd0, 2'd0, 32'h11, 32'h0);
        lane(1, 1, 1, 0, 5'd6, 3'd0, 2'd0, 32'h22, 32'h0);
        step();
        chk_ret("alu", 2'b11, 2'b11, 64'd0, 64'd1, 4'd2);
        chk("alu.waddr", 64'(rf_waddr_o), 64'({5'd6, 5'd5}));
        chk("alu.wdata", 64'(rf_wdata_o), {32'h22, 32'h11});

        // LB / LHU
        lane(0, 1, 1, 1, 5'd8, 3'b000, 2'd3, 32'h0, 32'h80FF_0000);
        lane(1, 1, 1, 1, 5'd9, 3'b101, 2'd2, 32'h0, 32'h80FF_0000);
        step();
        chk_ret("lb_lhu", 2'b11, 2'b11, 64'd2, 64'd3, 4'd4);
        chk("lb.data",  64'(rf_wdata_o[31:0]),  64'hFFFF_FF80);
        chk("lhu.data", 64'(rf_wdata_o[63:32]), 64'h0000_80FF);

        // LH / LBU
        lane(0, 1, 1, 1, 5'd8, 3'b001, 2'd0, 32'h0, 32'h1234_8001);
        lane(1, 1, 1, 1, 5'd9, 3'b100, 2'd1, 32'h0, 32'h0000_AB00);
        step();
        chk("lh.data",  64'(rf_wdata_o[31:0]),  64'hFFFF_8001);
        chk("lbu.data", 64'(rf_wdata_o[63:32]), 64'h0000_00AB);

        // LW with other shift leaves line unshifted; ALU lane alongside
        lane(0, 1, 1, 1, 5'd3, 3'b010, 2'd2, 32'h0, 32'hDEAD_BEEF);
        lane(1, 1, 1, 0, 5'd4, 3'b000, 2'd3, 32'h1357, 32'hFFFF_FFFF);
        step();
        chk("lw.data",  64'(rf_wdata_o[31:0]),  64'hDEAD_BEEF);
        chk("alu1.data", 64'(rf_wdata_o[63:32]), 64'h1357);
        chk_ret("lw", 2'b11, 2'b11, 64'd6, 64'd7, 4'd8);

        // Same rd on both lanes: younger lane wins
        lane(0, 1, 1, 0, 5'd7, 3'd0, 2'd0, 32'hA, 32'h0);
        lane(1, 1, 1, 0, 5'd7, 3'd0, 2'd0, 32'hB, 32'h0);
        step();
        chk_ret("samerd", 2'b11, 2'b10, 64'd8, 64'd9, 4'd10);
        chk("samerd.wdata1", 64'(rf_wdata_o[63:32]), 64'hB);

        // Write to x0, lane1 invalid: still presents a computed order
        lane(0, 1, 1, 0, 5'd0, 3'd0, 2'd0, 32'h55, 32'h0);
        lane(1, 0, 1, 0, 5'd3, 3'd0, 2'd0, 32'h66, 32'h0);
        step();
        chk_ret("x0", 2'b01, 2'b00, 64'd10, 64'd11, 4'd11);
        chk("x0.wdata0", 64'(rf_wdata_o[31:0]), 64'd0);

        // Data-side stall for three cycles: bubbles, everything held
        lane(0, 1, 1, 0, 5'd10, 3'd0, 2'd0, 32'h1, 32'h0);
        lane(1, 1, 1, 0, 5'd11, 3'd0, 2'd0, 32'h2, 32'h0);
        dside_stall_n_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ret("stall", 2'b00, 2'b00, 64'd10, 64'd11, 4'd11);
            chk("stall.waddr", 64'(rf_waddr_o), 64'({5'd3, 5'd0}));
        end
        dside_stall_n_i = 1'b1;
        step();
        chk_ret("resume", 2'b11, 2'b11, 64'd11, 64'd12, 4'd13);

        // Instruction-side stall also bubbles
        istall_n_i = 1'b0;
        step();
        chk_ret("istall", 2'b00, 2'b00, 64'd11, 64'd12, 4'd13);
        istall_n_i = 1'b1;

        // Flush with both lanes valid: no retire, base unchanged
        flush_i = 1'b1;
        step();
        chk_ret("flush", 2'b00, 2'b00, 64'd11, 64'd12, 4'd13);
        flush_i = 1'b0;

        // Gap: only lane1 valid; dense order
        lane(0, 0, 1, 0, 5'd12, 3'd0, 2'd0, 32'h3, 32'h0);
        lane(1, 1, 1, 0, 5'd13, 3'd0, 2'd0, 32'h4, 32'h0);
        step();
        chk_ret("gap", 2'b10, 2'b10, 64'd13, 64'd13, 4'd14);

        // Counter at max-1, retire 2 -> saturates at 15
        lane(0, 1, 1, 0, 5'd1, 3'd0, 2'd0, 32'h5, 32'h0);
        lane(1, 1, 1, 0, 5'd2, 3'd0, 2'd0, 32'h6, 32'h0);
        step();
        chk_ret("sat", 2'b11, 2'b11, 64'd14, 64'd15, 4'd15);
        step();
        chk_ret("sat2", 2'b11, 2'b11, 64'd16, 64'd17, 4'd15);

        // Asynchronous reset mid-stream
        #2 rst_ni = 1'b0;
        #1;
        chk_ret("arst", 2'b00, 2'b00, 64'd0, 64'd0, 4'd0);
        chk("arst.wdata", 64'(rf_wdata_o), 64'd0);
        step();
        @(negedge clk_i) rst_ni = 1'b1;
        step();
        chk_ret("post_rst", 2'b11, 2'b11, 64'd0, 64'd1, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
